dcache_write_responder: RTL and testbench



---
 rtl/dcache_write_responder.sv | 122 ++++++++++++
 tb/tb_dcache_write_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dcache_write_responder.sv
// dcache_write_responder: store-commit write responder with an in-order write buffer draining to memory.
// Ports: clk/rst (async active-high); dcWrite*_i request from the store committer,
// dcWriteBusy_o/dcWriteReqAck_o/dcWriteHit_o responses; writeBufferEmpty_o;
// memWrite*_o drain request held until memWriteAck_i.
// Define RSD_DCACHE_WRITE_COMBINE_EN to merge cacheable same-line writes into the youngest entry.
module dcache_write_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dcWriteReq_i,
  input  logic [ADDR_WIDTH-1:0]   dcWriteAddr_i,
  input  logic [LINE_BYTES*8-1:0] dcWriteData_i,
  input  logic [LINE_BYTES-1:0]   dcWriteByteWE_i,
  input  logic                    dcWriteUncachable_i,
  output logic                    dcWriteBusy_o,
  output logic                    dcWriteReqAck_o,
  output logic                    dcWriteHit_o,
  output logic                    writeBufferEmpty_o,
  output logic                    memWriteReq_o,
  output logic [ADDR_WIDTH-1:0]   memWriteAddr_o,
  output logic [LINE_BYTES*8-1:0] memWriteData_o,
  output logic [LINE_BYTES-1:0]   memWriteByteWE_o,
  output logic                    memWriteUncachable_o,
  input  logic                    memWriteAck_i
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int DW = LINE_BYTES * 8;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, wr_idx;
  logic [CW-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q [BUF_DEPTH];
  logic [DW-1:0] data_q [BUF_DEPTH];
  logic [LINE_BYTES-1:0] be_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] unc_q;
  logic ack_q, hit_q, munc_q, munc_d, accept, merge, load, pop;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mdata_q, mdata_d, wr_data, head_data;
  logic [LINE_BYTES-1:0] mbe_q, mbe_d, wr_be, head_be;
  assign dcWriteBusy_o = count_q == CW'(BUF_DEPTH);
  assign accept = dcWriteReq_i && !dcWriteBusy_o;
  assign load = state_q == IDLE && count_q != '0;
  assign pop = state_q == ISSUE && memWriteAck_i;
`ifdef RSD_DCACHE_WRITE_COMBINE_EN
  logic [PW-1:0] young;
  assign young = tail_q - PW'(1);
  assign merge = accept && count_q != '0 && addr_q[young] == (dcWriteAddr_i & LINE_MASK) &&
                 !unc_q[young] && !dcWriteUncachable_i && !(young == head_q && state_q == ISSUE);
  always_comb begin
    wr_data = dcWriteData_i;
    for (int b = 0; b < LINE_BYTES; b++)
      wr_data[b*8 +: 8] = (merge && !dcWriteByteWE_i[b]) ? data_q[young][b*8 +: 8] : dcWriteData_i[b*8 +: 8];
  end
  assign wr_be = merge ? (be_q[young] | dcWriteByteWE_i) : dcWriteByteWE_i;
  assign wr_idx = merge ? young : tail_q;
  // A merge into the head while IDLE coincides with the head being latched for drain,
  // so the drain must see the merged line rather than the stale one.
  assign head_data = (merge && young == head_q) ? wr_data : data_q[head_q];
  assign head_be = (merge && young == head_q) ? wr_be : be_q[head_q];
`else
  assign merge = 1'b0;
  assign wr_data = dcWriteData_i;
  assign wr_be = dcWriteByteWE_i;
  assign wr_idx = tail_q;
  assign head_data = data_q[head_q];
  assign head_be = be_q[head_q];
`endif
  always_comb begin
    state_d = load ? ISSUE : pop ? IDLE : state_q;
    head_d = pop ? head_q + PW'(1) : head_q;
    tail_d = (accept && !merge) ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(accept && !merge) - CW'(pop);
    maddr_d = load ? addr_q[head_q] : maddr_q;
    mdata_d = load ? head_data : mdata_q;
    mbe_d = load ? head_be : mbe_q;
    munc_d = load ? unc_q[head_q] : munc_q;
  end
  always_ff @(posedge clk)
    if (accept) begin
      addr_q[wr_idx] <= dcWriteAddr_i & LINE_MASK;
      data_q[wr_idx] <= wr_data;
      be_q[wr_idx] <= wr_be;
      unc_q[wr_idx] <= dcWriteUncachable_i;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      ack_q <= 1'b0;
      hit_q <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      mbe_q <= '0;
      munc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      ack_q <= accept;
      hit_q <= merge;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mbe_q <= mbe_d;
      munc_q <= munc_d;
    end
  assign dcWriteReqAck_o = ack_q;
  assign dcWriteHit_o = hit_q;
  assign writeBufferEmpty_o = count_q == '0;
  assign memWriteReq_o = state_q == ISSUE;
  assign memWriteAddr_o = maddr_q;
  assign memWriteData_o = mdata_q;
  assign memWriteByteWE_o = mbe_q;
  assign memWriteUncachable_o = munc_q;
endmodule

// File: tb/tb_dcache_write_responder.sv
// tb_dcache_write_responder: directed self-checking bench for dcache_write_responder.
module tb_dcache_write_responder;
`ifdef RSD_DCACHE_WRITE_COMBINE_EN
  localparam logic COMB = 1'b1;
`else
  localparam logic COMB = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic req = 0, unc = 0, mack = 0;
  logic [31:0] addr = '0;
  logic [127:0] data = '0;
  logic [15:0] we = '0;
  logic busy, ack, hit, empty, mreq, munc;
  logic [31:0] maddr;
  logic [127:0] mdata;
  logic [15:0] mbe;
  int n_chk = 0, n_pass = 0;
  dcache_write_responder dut (
    .clk(clk), .rst(rst),
    .dcWriteReq_i(req), .dcWriteAddr_i(addr), .dcWriteData_i(data),
    .dcWriteByteWE_i(we), .dcWriteUncachable_i(unc),
    .dcWriteBusy_o(busy), .dcWriteReqAck_o(ack), .dcWriteHit_o(hit),
    .writeBufferEmpty_o(empty), .memWriteReq_o(mreq), .memWriteAddr_o(maddr),
    .memWriteData_o(mdata), .memWriteByteWE_o(mbe), .memWriteUncachable_o(munc),
    .memWriteAck_i(mack)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wr(input string tag, input logic [31:0] a, input logic [127:0] d,
                    input logic [15:0] be, input logic u, input logic exp_hit);
    req = 1; addr = a; data = d; we = be; unc = u;
    tick();
    check({tag, "_ack"}, ack, 1'b1);
    check({tag, "_hit"}, hit, exp_hit);
    req = 0;
  endtask
  task automatic drain(input string tag, input logic [31:0] a, input logic [127:0] d,
                       input logic [15:0] be, input logic u);
    for (int i = 0; i < 8 && !mreq; i++) tick();
    check({tag, "_req"}, mreq, 1'b1);
    check({tag, "_addr"}, maddr, a);
    check({tag, "_be"}, mbe, be);
    check({tag, "_unc"}, munc, u);
    check({tag, "_data"}, mdata, d);
    mack = 1;
    tick();
    mack = 0;
    check({tag, "_pop"}, mreq, 1'b0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int seen;
    tick(); tick();
    check("rst_mreq", mreq, 0);
    check("rst_ack", ack, 0);
    check("rst_hit", hit, 0);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_maddr", maddr, 0);
    check("rst_mdata", mdata, 0);
    check("rst_mbe", mbe, 0);
    check("rst_munc", munc, 0);
    rst = 0;
    tick();
    // single write, memory ack held high
    mack = 1;
    wr("single", 32'h1004, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 16'h00F0, 0, 0);
    check("single_empty0", empty, 0);
    check("single_noreq", mreq, 0);
    tick();
    check("single_req", mreq, 1);
    check("single_addr", maddr, 32'h1000);
    check("single_be", mbe, 16'h00F0);
    check("single_data", mdata, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
    tick();
    check("single_empty", empty, 1);
    check("single_done", mreq, 0);
    mack = 0;
    tick();
    // combining sequence, memory ack held low
    wr("cmbA", 32'h1000, {4{32'h1111_1111}}, 16'h000F, 0, 0);
    wr("cmbB", 32'h2000, {4{32'h2222_2222}}, 16'h000F, 0, 0);
    wr("cmbC", 32'h2008, {4{32'h3333_3333}}, 16'h0F00, 0, COMB);
    tick();
    drain("drA", 32'h1000, {4{32'h1111_1111}}, 16'h000F, 0);
`ifdef RSD_DCACHE_WRITE_COMBINE_EN
    drain("drB", 32'h2000, 128'h2222_2222_3333_3333_2222_2222_2222_2222, 16'h0F0F, 0);
`else
    drain("drB", 32'h2000, {4{32'h2222_2222}}, 16'h000F, 0);
    drain("drC", 32'h2000, {4{32'h3333_3333}}, 16'h0F00, 0);
`endif
    check("cmb_empty", empty, 1);
    // uncachable tail blocks combining
    wr("ucA", 32'h3000, {4{32'h5555_5555}}, 16'h00FF, 1, 0);
    wr("ucB", 32'h3000, {4{32'h6666_6666}}, 16'hFF00, 0, 0);
    drain("druA", 32'h3000, {4{32'h5555_5555}}, 16'h00FF, 1);
    drain("druB", 32'h3000, {4{32'h6666_6666}}, 16'hFF00, 0);
    check("uc_empty", empty, 1);
    // fill to full, then one pop lets a fifth request in (tail wraps)
    wr("f0", 32'h4000, {4{32'h4000}}, 16'hFFFF, 0, 0);
    wr("f1", 32'h5000, {4{32'h5000}}, 16'hFFFF, 0, 0);
    wr("f2", 32'h6000, {4{32'h6000}}, 16'hFFFF, 0, 0);
    wr("f3", 32'h7000, {4{32'h7000}}, 16'hFFFF, 0, 0);
    check("full_busy", busy, 1);
    req = 1; addr = 32'h8000; data = {4{32'h8000}}; we = 16'hFFFF; unc = 0;
    tick();
    check("full_noack", ack, 0);
    check("full_busy2", busy, 1);
    check("full_head", maddr, 32'h4000);
    mack = 1;
    tick();
    mack = 0;
    check("pop_noack", ack, 0);
    check("pop_busy", busy, 0);
    tick();
    check("f4_ack", ack, 1);
    check("f4_hit", hit, 0);
    req = 0;
    drain("drf1", 32'h5000, {4{32'h5000}}, 16'hFFFF, 0);
    drain("drf2", 32'h6000, {4{32'h6000}}, 16'hFFFF, 0);
    drain("drf3", 32'h7000, {4{32'h7000}}, 16'hFFFF, 0);
    drain("drf4", 32'h8000, {4{32'h8000}}, 16'hFFFF, 0);
    check("full_empty", empty, 1);
    // reset while ISSUE with three entries pending
    wr("r0", 32'h9000, {4{32'h9000}}, 16'hFFFF, 0, 0);
    wr("r1", 32'hA000, {4{32'hA000}}, 16'hFFFF, 0, 0);
    wr("r2", 32'hB000, {4{32'hB000}}, 16'hFFFF, 0, 0);
    check("r_issue", mreq, 1);
    #1 rst = 1;
    #1;
    check("r_mreq", mreq, 0);
    check("r_empty", empty, 1);
    check("r_ack", ack, 0);
    check("r_maddr", maddr, 0);
    tick();
    #2 rst = 0;
    mack = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mreq) seen++;
    end
    mack = 0;
    check("r_nodrain", seen, 0);
    check("r_empty2", empty, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
